// File: rtl/ah_cam_pkg.sv
// Shared definitions for the AH CAM write path: entry width, CAM depth,
// credit counter width and the entry type used by both feeder and CAM.
package ah_cam_pkg;

   localparam int DATA_W    = 128;
   localparam int CAM_DEPTH = 20;
   localparam int CRED_W    = $clog2(CAM_DEPTH + 1);

   typedef logic [DATA_W-1:0] cam_entry_t;

endpackage

// File: rtl/ah_sync_fifo.sv
// Small synchronous skid FIFO with modulo pointers, an occupancy counter
// and a head output taken straight from the registered storage.
module ah_sync_fifo #(
   parameter int  DATA_W     = 128,
   parameter int  FIFO_DEPTH = 4,
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1),
   localparam int PTR_W      = $clog2(FIFO_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [LVL_W-1:0]  level
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_reg;
   logic [PTR_W-1:0]  rd_ptr_reg;
   logic [LVL_W-1:0]  level_reg;

   // Storage is not reset; the level counter alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + LVL_W'(1);
            2'b01:   level_reg <= level_reg - LVL_W'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign full  = (level_reg == LVL_W'(FIFO_DEPTH));
   assign empty = (level_reg == '0);
   assign level = level_reg;

endmodule

// File: rtl/ah_cam_wr_credit_tx.sv
// Credit-gated write feeder for the AH CAM: buffers producer entries in a
// skid FIFO and issues one registered write pulse per available credit.
module ah_cam_wr_credit_tx #(
   parameter int  DATA_W     = ah_cam_pkg::DATA_W,
   parameter int  CAM_DEPTH  = ah_cam_pkg::CAM_DEPTH,
   parameter int  FIFO_DEPTH = 4,
   localparam int CRED_W     = $clog2(CAM_DEPTH + 1),
   localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              wvalid,
   output logic [DATA_W-1:0] wdata,
   input  logic              wcredit,
   output logic [CRED_W-1:0] credit_cnt,
   output logic [LVL_W-1:0]  fifo_level,
   output logic              idle,
   output logic              err_credit_ovf
);

   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(CAM_DEPTH);

   logic [CRED_W-1:0] credit_reg, credit_next;
   logic              err_reg, err_next;
   logic              wvalid_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] head;
   logic              full, empty;
   logic              push, issue;

   assign push  = in_valid & ~full;
   assign issue = ~empty & (credit_reg != '0);

   ah_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (in_data),
      .pop       (issue),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .level     (fifo_level)
   );

   // A returned credit while already full is a CAM-side bookkeeping bug:
   // saturate and flag it rather than wrapping.
   always_comb begin
      credit_next = credit_reg;
      err_next    = err_reg;
      if (issue && !wcredit) begin
         credit_next = credit_reg - CRED_W'(1);
      end else if (!issue && wcredit) begin
         if (credit_reg == CRED_FULL) begin
            err_next = 1'b1;
         end else begin
            credit_next = credit_reg + CRED_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_reg <= CRED_FULL;
         err_reg    <= 1'b0;
         wvalid_reg <= 1'b0;
         wdata_reg  <= '0;
      end else begin
         credit_reg <= credit_next;
         err_reg    <= err_next;
         wvalid_reg <= issue;
         if (issue) begin
            wdata_reg <= head;
         end
      end
   end

   assign in_ready       = ~full;
   assign wvalid         = wvalid_reg;
   assign wdata          = wdata_reg;
   assign credit_cnt     = credit_reg;
   assign err_credit_ovf = err_reg;
   assign idle           = empty & (credit_reg == CRED_FULL);

endmodule

// File: tb/tb_ah_cam_wr_credit_tx.sv
// Self-checking bench for ah_cam_wr_credit_tx: directed vector table, hand
// sequences for credit exhaustion/return and reset, plus random traffic.
module tb_ah_cam_wr_credit_tx;
   import ah_cam_pkg::*;

   localparam int FD = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   cam_entry_t        in_data;
   logic              wvalid;
   cam_entry_t        wdata;
   logic              wcredit;
   logic [CRED_W-1:0] credit_cnt;
   logic [2:0]        fifo_level;
   logic              idle;
   logic              err_credit_ovf;

   int total = 0;
   int bad   = 0;

   ah_cam_wr_credit_tx #(
      .DATA_W     (DATA_W),
      .CAM_DEPTH  (CAM_DEPTH),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .wvalid         (wvalid),
      .wdata          (wdata),
      .wcredit        (wcredit),
      .credit_cnt     (credit_cnt),
      .fifo_level     (fifo_level),
      .idle           (idle),
      .err_credit_ovf (err_credit_ovf)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of waiting entries and an integer credit pool.
   cam_entry_t mq[$];
   int         m_cred;
   logic       m_wv;
   cam_entry_t m_wd;
   logic       m_err;
   logic       m_acc;

   typedef struct {
      logic       r;
      logic       v;
      cam_entry_t d;
      logic       wc;
      logic       e_wv;
      cam_entry_t e_wd;
      int         e_cred;
      int         e_lvl;
      logic       e_rdy;
      logic       e_idle;
      logic       e_err;
   } vec_t;

   vec_t tbl[8];

   function automatic cam_entry_t ent(int k);
      return {32'hC0DE_0000 ^ 32'(k), 32'(k) * 32'h9E37_79B1, ~32'(k), 32'(k)};
   endfunction

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic v, input cam_entry_t d,
                             input logic wc);
      bit iss;
      if (r) begin
         mq.delete();
         m_cred = CAM_DEPTH;
         m_wv   = 1'b0;
         m_wd   = '0;
         m_err  = 1'b0;
         m_acc  = 1'b0;
      end else begin
         iss   = (mq.size() != 0) && (m_cred != 0);
         m_acc = v && (mq.size() != FD);
         m_wv  = iss;
         if (iss) m_wd = mq.pop_front();
         if (iss && !wc) m_cred = m_cred - 1;
         else if (!iss && wc) begin
            if (m_cred == CAM_DEPTH) m_err = 1'b1;
            else m_cred = m_cred + 1;
         end
         if (m_acc) mq.push_back(d);
      end
   endtask

   task automatic step(input logic r, input logic v, input cam_entry_t d,
                       input logic wc);
      rst = r; in_valid = v; in_data = d; wcredit = wc;
      @(posedge clk);
      model_edge(r, v, d, wc);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".wvalid"},   wvalid, m_wv);
      chk({tag, ".wdata"},    wdata, m_wd);
      chk({tag, ".credit"},   credit_cnt, m_cred);
      chk({tag, ".level"},    fifo_level, mq.size());
      chk({tag, ".in_ready"}, in_ready, mq.size() != FD);
      chk({tag, ".idle"},     idle, (mq.size() == 0) && (m_cred == CAM_DEPTH));
      chk({tag, ".err"},      err_credit_ovf, m_err);
   endtask

   initial begin
      int         k;
      int         pulses;
      logic       cur_v;
      cam_entry_t cur_d;
      logic       r, wc;
      string      t;

      rst = 1'b1; in_valid = 1'b0; in_data = '0; wcredit = 1'b0;

      //           r  v  d        wc  wv wd      cred lvl rdy idle err
      tbl[0] = '{1, 0, '0,      0,  0, '0,     20,  0,  1,  1,   0};
      tbl[1] = '{0, 1, 'hA5,    0,  0, '0,     20,  1,  1,  0,   0};
      tbl[2] = '{0, 0, '0,      0,  1, 'hA5,   19,  0,  1,  0,   0};
      tbl[3] = '{0, 0, '0,      0,  0, 'hA5,   19,  0,  1,  0,   0};
      tbl[4] = '{0, 0, '0,      1,  0, 'hA5,   20,  0,  1,  1,   0};
      tbl[5] = '{0, 0, '0,      1,  0, 'hA5,   20,  0,  1,  1,   1};
      tbl[6] = '{0, 0, '0,      0,  0, 'hA5,   20,  0,  1,  1,   1};
      tbl[7] = '{1, 0, '0,      0,  0, '0,     20,  0,  1,  1,   0};

      repeat (2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].wc);
         t = $sformatf("tbl%0d", i);
         chk({t, ".wvalid"},   wvalid, tbl[i].e_wv);
         chk({t, ".wdata"},    wdata, tbl[i].e_wd);
         chk({t, ".credit"},   credit_cnt, tbl[i].e_cred);
         chk({t, ".level"},    fifo_level, tbl[i].e_lvl);
         chk({t, ".in_ready"}, in_ready, tbl[i].e_rdy);
         chk({t, ".idle"},     idle, tbl[i].e_idle);
         chk({t, ".err"},      err_credit_ovf, tbl[i].e_err);
         $display("vec %0d: wvalid=%0b credit=%0d level=%0d idle=%0b err=%0b",
                  i, wvalid, credit_cnt, fifo_level, idle, err_credit_ovf);
      end

      // Exhaust all credits with a continuous producer and no returns.
      k = 0; pulses = 0;
      for (int c = 0; c < 40; c++) begin
         step(1'b0, 1'b1, ent(k), 1'b0);
         if (m_acc) k++;
         check_model("stream");
         if (wvalid) pulses++;
      end
      chk("stream.pulses", pulses, 20);
      chk("stream.accepted", k, 24);
      chk("stream.credit_zero", credit_cnt, 0);
      chk("stream.level_full", fifo_level, FD);
      chk("stream.ready_low", in_ready, 1'b0);
      $display("stream: pulses=%0d accepted=%0d credit=%0d level=%0d",
               pulses, k, credit_cnt, fifo_level);

      // A single returned credit releases exactly one waiting head.
      step(1'b0, 1'b1, ent(k), 1'b1);
      check_model("cret0");
      chk("cret0.no_issue", wvalid, 1'b0);
      chk("cret0.credit_one", credit_cnt, 1);
      step(1'b0, 1'b1, ent(k), 1'b0);
      check_model("cret1");
      chk("cret1.wvalid", wvalid, 1'b1);
      chk("cret1.wdata", wdata, ent(20));
      chk("cret1.credit_zero", credit_cnt, 0);
      chk("cret1.ready", in_ready, 1'b1);
      step(1'b0, 1'b1, ent(k), 1'b0);
      if (m_acc) k++;
      check_model("cret2");
      chk("cret2.accepted", k, 25);
      chk("cret2.level_full", fifo_level, FD);
      $display("credit return: accepted=%0d level=%0d credit=%0d", k, fifo_level, credit_cnt);

      // Reset with entries still queued and credits partly consumed.
      step(1'b0, 1'b0, '0, 1'b1);
      check_model("mid0");
      step(1'b0, 1'b0, '0, 1'b1);
      check_model("mid1");
      chk("mid1.level", fifo_level, 3);
      step(1'b1, 1'b0, '0, 1'b0);
      chk("rst.level", fifo_level, 0);
      chk("rst.credit", credit_cnt, CAM_DEPTH);
      chk("rst.wvalid", wvalid, 1'b0);
      chk("rst.err", err_credit_ovf, 1'b0);
      chk("rst.wdata", wdata, '0);
      $display("mid reset: level=%0d credit=%0d wvalid=%0b", fifo_level, credit_cnt, wvalid);
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 1'b0, '0, 1'b0);
         check_model("post_rst");
      end

      // Steady stream with a credit returned on every issue cycle.
      step(1'b1, 1'b0, '0, 1'b0);
      k = 0; pulses = 0;
      for (int c = 0; c < 40; c++) begin
         wc = (mq.size() != 0) && (m_cred != 0);
         step(1'b0, 1'b1, ent(100 + k), wc);
         if (m_acc) k++;
         check_model("steady");
         chk("steady.credit", credit_cnt, CAM_DEPTH);
         if (wvalid) pulses++;
      end
      chk("steady.pulses", pulses, 39);
      $display("steady: pulses=%0d accepted=%0d credit=%0d", pulses, k, credit_cnt);

      // Random traffic against the model.
      step(1'b1, 1'b0, '0, 1'b0);
      cur_v = 1'b0; cur_d = '0; m_acc = 1'b0;
      for (int c = 0; c < 1500; c++) begin
         if (!cur_v || m_acc) begin
            cur_v = ($urandom_range(0, 9) < 7);
            cur_d = {$urandom, $urandom, $urandom, $urandom};
         end
         if (m_cred < CAM_DEPTH) wc = ($urandom_range(0, 2) == 0);
         else wc = ($urandom_range(0, 99) == 0);
         r = ($urandom_range(0, 299) == 0);
         step(r, cur_v, cur_d, wc);
         if (r) cur_v = 1'b0;
         check_model("rand");
         if (c % 100 == 0)
            $display("rand %0d: level=%0d credit=%0d wvalid=%0b err=%0b",
                     c, fifo_level, credit_cnt, wvalid, err_credit_ovf);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
